// File: rtl/piso_serializer_hs.sv
// Parallel-in serial-out serializer with valid/ready load handshake and gapless back-to-back words.
// Define SERIALIZER_PARITY_EN to append an even-parity cycle after the data bits of each word.
module piso_serializer_hs #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             done
);

`ifdef SERIALIZER_PARITY_EN
   localparam int NBITS = WIDTH + 1;
   localparam int CW    = $clog2(WIDTH + 2);
`else
   localparam int NBITS = WIDTH;
   localparam int CW    = $clog2(WIDTH + 1);
`endif
   localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_valid_q, ser_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;
`ifdef SERIALIZER_PARITY_EN
   localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
   logic             par_q, par_d;
`endif

   // The shift register holds the not-yet-emitted bits with the next one at the output end.
   logic             first_bit, next_bit;
   logic [WIDTH-1:0] shifted_load, shifted_reg;

   if (LSB_FIRST) begin : g_lsb
      assign first_bit    = load_data[0];
      assign shifted_load = load_data >> 1;
      assign next_bit     = shreg_q[0];
      assign shifted_reg  = shreg_q >> 1;
   end else begin : g_msb
      assign first_bit    = load_data[WIDTH-1];
      assign shifted_load = load_data << 1;
      assign next_bit     = shreg_q[WIDTH-1];
      assign shifted_reg  = shreg_q << 1;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      ser_out_d   = ser_out_q;
      ser_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_d       = par_q;
`endif
      // Ready in IDLE and in the final cycle of a word, which makes back-to-back gapless.
      load_ready  = (state_q == IDLE) || (cnt_q == LAST);
      accept      = load_valid && load_ready;

      if (accept) begin
         state_d     = SHIFT;
         cnt_d       = '0;
         shreg_d     = shifted_load;
         ser_out_d   = first_bit;
         ser_valid_d = 1'b1;
         busy_d      = 1'b1;
`ifdef SERIALIZER_PARITY_EN
         par_d       = ^load_data;
`endif
      end else if ((state_q == SHIFT) && (cnt_q != LAST)) begin
         cnt_d       = cnt_q + CW'(1);
         shreg_d     = shifted_reg;
`ifdef SERIALIZER_PARITY_EN
         ser_out_d   = (cnt_q == LAST_DATA) ? par_q : next_bit;
`else
         ser_out_d   = next_bit;
`endif
         ser_valid_d = 1'b1;
         busy_d      = 1'b1;
         done_d      = (cnt_d == LAST);
      end else begin
         state_d   = IDLE;
         cnt_d     = '0;
         shreg_d   = '0;
         ser_out_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef SERIALIZER_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign ser_out   = ser_out_q;
   assign ser_valid = ser_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer_hs.sv
// Bench for piso_serializer_hs: LSB-first and MSB-first instances share stimulus; a queue
// scoreboard holds the expected serial bits of every accepted word.
module tb_piso_serializer_hs;
   localparam int W = 4;
`ifdef SERIALIZER_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] load_data = '0;
   logic         load_valid = 1'b0;
   logic         ready_a, out_a, valid_a, busy_a, done_a;
   logic         ready_b, out_b, valid_b, busy_b, done_b;

   int errors = 0;
   int checks = 0;

   bit exp_a[$];
   bit exp_b[$];
   int m_pos = -1;
   bit e_valid, e_done, e_ready, e_out_a, e_out_b;

   always #5 clk = ~clk;

   piso_serializer_hs #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
      .load_ready(ready_a), .ser_out(out_a), .ser_valid(valid_a), .busy(busy_a), .done(done_a)
   );

   piso_serializer_hs #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
      .load_ready(ready_b), .ser_out(out_b), .ser_valid(valid_b), .busy(busy_b), .done(done_b)
   );

   function automatic bit m_ready();
      return (m_pos < 0) || (m_pos == NB - 1);
   endfunction

   // Advance one clock, updating the reference model; expectations for the new cycle land in e_*.
   task automatic tick(output bit acc);
      acc = !reset && load_valid && m_ready();
      if (reset) begin
         m_pos = -1;
         exp_a.delete();
         exp_b.delete();
      end else if (acc) begin
         m_pos = 0;
         for (int i = 0; i < W; i++) begin
            exp_a.push_back(load_data[i]);
            exp_b.push_back(load_data[W-1-i]);
         end
`ifdef SERIALIZER_PARITY_EN
         exp_a.push_back(^load_data);
         exp_b.push_back(^load_data);
`endif
         $display("accept word %b at %0t", load_data, $time);
      end else if (m_pos >= 0) begin
         m_pos = (m_pos == NB - 1) ? -1 : m_pos + 1;
      end
      @(posedge clk);
      #1;
      e_valid = (m_pos >= 0);
      e_done  = (m_pos == NB - 1);
      e_ready = m_ready();
      e_out_a = 1'b0;
      e_out_b = 1'b0;
      if (e_valid && exp_a.size() > 0) begin
         e_out_a = exp_a.pop_front();
         e_out_b = exp_b.pop_front();
      end
   endtask

   task automatic test_reset();
      bit acc;
      reset = 1'b1; load_valid = 1'b1; load_data = 4'hF;
      for (int c = 0; c < 3; c++) begin
         tick(acc);
         checks++;
         if ({valid_a, busy_a, done_a, out_a, ready_a} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_state c%0d got v/b/d/o/r=%b want 00001", c, {valid_a, busy_a, done_a, out_a, ready_a});
         end
      end
      reset = 1'b0; load_valid = 1'b0;
      $display("reset released");
   endtask

   task automatic test_idle();
      bit acc;
      load_valid = 1'b0; load_data = 4'h6;
      for (int c = 0; c < 4; c++) begin
         tick(acc);
         checks++;
         if ({valid_a, busy_a, done_a, out_a, ready_a, valid_b} !== {4'b0000, e_ready, 1'b0}) begin
            errors++;
            $display("FAIL idle_hold c%0d got v/b/d/o/r/vb=%b want 000010", c, {valid_a, busy_a, done_a, out_a, ready_a, valid_b});
         end
      end
   endtask

   task automatic test_single();
      bit acc;
      load_valid = 1'b1; load_data = 4'b1011;
      for (int c = 0; c < NB + 2; c++) begin
         tick(acc);
         if (acc) load_valid = 1'b0;
         checks++;
         if (valid_a !== e_valid || busy_a !== e_valid || valid_b !== e_valid) begin
            errors++;
            $display("FAIL single_valid c%0d got va/ba/vb=%b%b%b want %b", c, valid_a, busy_a, valid_b, e_valid);
         end
         checks++;
         if (done_a !== e_done || done_b !== e_done) begin
            errors++;
            $display("FAIL single_done c%0d got %b%b want %b", c, done_a, done_b, e_done);
         end
         checks++;
         if (ready_a !== e_ready) begin
            errors++;
            $display("FAIL single_ready c%0d got %b want %b", c, ready_a, e_ready);
         end
         if (e_valid) begin
            checks++;
            if (out_a !== e_out_a || out_b !== e_out_b) begin
               errors++;
               $display("FAIL single_bit c%0d got lsb/msb=%b%b want %b%b", c, out_a, out_b, e_out_a, e_out_b);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit acc;
      int n_acc = 0;
      load_valid = 1'b1; load_data = 4'hA;
      for (int c = 0; c < 2 * NB + 2; c++) begin
         tick(acc);
         if (acc) begin
            n_acc++;
            load_data = 4'h5;
            if (n_acc == 2) load_valid = 1'b0;
         end
         checks++;
         if (valid_a !== e_valid || busy_a !== e_valid || done_a !== e_done) begin
            errors++;
            $display("FAIL b2b_ctrl c%0d got v/b/d=%b%b%b want %b%b%b", c, valid_a, busy_a, done_a, e_valid, e_valid, e_done);
         end
         checks++;
         if (ready_a !== e_ready || ready_b !== e_ready) begin
            errors++;
            $display("FAIL b2b_ready c%0d got %b%b want %b", c, ready_a, ready_b, e_ready);
         end
         if (e_valid) begin
            checks++;
            if (out_a !== e_out_a || out_b !== e_out_b) begin
               errors++;
               $display("FAIL b2b_bit c%0d got lsb/msb=%b%b want %b%b", c, out_a, out_b, e_out_a, e_out_b);
            end
         end
      end
   endtask

   task automatic test_hold_data();
      bit acc;
      int n_acc = 0;
      int second_at = -1;
      load_valid = 1'b1; load_data = 4'b1111;
      for (int c = 0; c < 2 * NB + 2; c++) begin
         tick(acc);
         if (acc) begin
            n_acc++;
            if (n_acc == 2) begin
               second_at = c;
               load_valid = 1'b0;
            end
            load_data = 4'b0000;
         end
         checks++;
         if (valid_a !== e_valid || done_a !== e_done || ready_a !== e_ready) begin
            errors++;
            $display("FAIL hold_ctrl c%0d got v/d/r=%b%b%b want %b%b%b", c, valid_a, done_a, ready_a, e_valid, e_done, e_ready);
         end
         if (e_valid) begin
            checks++;
            if (out_a !== e_out_a || out_b !== e_out_b) begin
               errors++;
               $display("FAIL hold_bit c%0d got lsb/msb=%b%b want %b%b", c, out_a, out_b, e_out_a, e_out_b);
            end
         end
      end
      checks++;
      if (second_at != NB) begin
         errors++;
         $display("FAIL hold_accept_cycle got %0d want %0d", second_at, NB);
      end
   endtask

   task automatic test_reset_mid();
      bit acc;
      load_valid = 1'b1; load_data = 4'b1011;
      for (int c = 0; c < 2; c++) begin
         tick(acc);
         if (acc) load_valid = 1'b0;
         checks++;
         if (valid_a !== e_valid || out_a !== e_out_a || out_b !== e_out_b) begin
            errors++;
            $display("FAIL rstmid_bit c%0d got v/lsb/msb=%b%b%b want %b%b%b", c, valid_a, out_a, out_b, e_valid, e_out_a, e_out_b);
         end
      end
      reset = 1'b1; load_valid = 1'b1;
      tick(acc);
      reset = 1'b0; load_valid = 1'b0;
      checks++;
      if ({valid_a, busy_a, done_a, out_a, ready_a, valid_b} !== {4'b0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rstmid_abort got v/b/d/o/r/vb=%b want 000010", {valid_a, busy_a, done_a, out_a, ready_a, valid_b});
      end
      for (int c = 0; c < NB; c++) begin
         tick(acc);
         checks++;
         if (valid_a !== 1'b0 || valid_b !== 1'b0 || ready_a !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle c%0d got va/vb/r=%b%b%b want 001", c, valid_a, valid_b, ready_a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_hold_data();
      test_reset_mid();
      test_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
